// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - PC, instruction memory and decode port bundle for the fetch sequencer
interface fetch_unit_if #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 9,
  parameter int CNT_W   = 16
);
  logic [ADDR_W-1:0]  pc_addr;
  logic               pc_enable;
  logic               mem_req;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_ack;
  logic [INSTR_W-1:0] mem_rdata;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_addr;
  logic               instr_ready;
  logic               halt;
  logic               halted;
  logic [CNT_W-1:0]   retired_cnt;

  modport master (
    input  pc_addr, mem_ack, mem_rdata, instr_ready, halt,
    output pc_enable, mem_req, mem_addr, instr_valid, instr, instr_addr, halted, retired_cnt
  );

  modport slave (
    output pc_addr, mem_ack, mem_rdata, instr_ready, halt,
    input  pc_enable, mem_req, mem_addr, instr_valid, instr, instr_addr, halted, retired_cnt
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch sequencer: memory request, decode handshake, PC advance
module fetch_unit #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 9,
  parameter int CNT_W   = 16
) (
  input  logic          clk,
  input  logic          reset,
  fetch_unit_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    HOLD   = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  instr_addr_q, instr_addr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  always_comb begin
    state_d      = state_q;
    instr_d      = instr_q;
    instr_addr_d = instr_addr_q;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (bus.mem_ack) begin
          instr_d      = bus.mem_rdata;
          instr_addr_d = bus.pc_addr;
          state_d      = HOLD;
        end
      end
      HOLD: begin
        // halt only matters on the cycle decode actually takes the instruction
        if (bus.instr_ready) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = bus.halt ? HALTED : REQ;
        end
      end
      HALTED: state_d = HALTED;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      instr_q      <= '0;
      instr_addr_q <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      instr_q      <= instr_d;
      instr_addr_q <= instr_addr_d;
      cnt_q        <= cnt_d;
    end
  end

  // request and PC advance decode straight from state so zero-wait memory works
  assign bus.mem_req     = (state_q == REQ);
  assign bus.mem_addr    = bus.pc_addr;
  assign bus.pc_enable   = (state_q == HOLD) && bus.instr_ready && !bus.halt;
  assign bus.instr_valid = (state_q == HOLD);
  assign bus.halted      = (state_q == HALTED);
  assign bus.instr       = instr_q;
  assign bus.instr_addr  = instr_addr_q;
  assign bus.retired_cnt = cnt_q;

endmodule
